ps2_scan_collector: RTL and testbench

- Upstream stage of the keyboard path. Receives raw PS/2 device-to-host frames and checks framing and parity.
- Strips break (F0) sequences and tags extended (E0) codes.
- Presents one 32-bit make code per key press, with a one-cycle strobe, to the scan-code-to-ASCII decoder.
- Output is zero-extended, so plain keys compare directly against 8-bit table entries. Extended keys carry E0 in bits [15:8].

---
 rtl/ps2_scan_collector.sv | 147 ++++++++++++++
 tb/tb_ps2_scan_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_collector.sv
// PS/2 device-to-host receiver: conditions ps2c/ps2d, checks framing and odd parity,
// drops break sequences and presents one zero-extended make code per key press.
module ps2_scan_collector #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2c,
    input  logic        ps2d,
    output logic [31:0] scan_code,
    output logic        scan_done_tick,
    output logic        frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RX    = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic                  c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fc_q, fc_d, fc_prev_q;
    logic                  fall;
    logic [1:0]            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [8:0]            shift_q, shift_d;
    logic                  brk_q, brk_d, ext_q, ext_d;
    logic [15:0]           code_q, code_d;
    logic                  tick_q, tick_d, err_q, err_d;
    logic [9:0]            frame_w;

    assign fall    = fc_prev_q & ~fc_q;
    // The 10th fall carries the stop bit live on d_sync_q; frame_w[9] is stop, [8] parity.
    assign frame_w = {d_sync_q, shift_q};

    always_comb begin
        filt_d    = {filt_q[FILTER_LEN-2:0], c_sync_q};
        fc_d      = fc_q;
        if (&filt_q) begin
            fc_d = 1'b1;
        end else if (~|filt_q) begin
            fc_d = 1'b0;
        end

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        code_d    = code_q;
        tick_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall && !d_sync_q) begin
                    state_d   = ST_RX;
                    bit_cnt_d = 4'd0;
                    tmo_d     = '0;
                end
            end
            ST_RX: begin
                if (fall) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    shift_d   = {d_sync_q, shift_q[8:1]};
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_CHECK;
                        if (!(^frame_w[8:0]) || !frame_w[9]) begin
                            err_d = 1'b1;
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else if (frame_w[7:0] == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (frame_w[7:0] == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (brk_q) begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else begin
                            code_d = {(ext_q ? 8'hE0 : 8'h00), frame_w[7:0]};
                            tick_d = 1'b1;
                            ext_d  = 1'b0;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    brk_d   = 1'b0;
                    ext_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_meta_q  <= 1'b1;
            c_sync_q  <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
            filt_q    <= '1;
            fc_q      <= 1'b1;
            fc_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            tmo_q     <= '0;
            shift_q   <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            code_q    <= 16'h0000;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            c_meta_q  <= ps2c;
            c_sync_q  <= c_meta_q;
            d_meta_q  <= ps2d;
            d_sync_q  <= d_meta_q;
            filt_q    <= filt_d;
            fc_q      <= fc_d;
            fc_prev_q <= fc_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            shift_q   <= shift_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            code_q    <= code_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

    assign scan_code      = {16'h0000, code_q};
    assign scan_done_tick = tick_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_ps2_scan_collector.sv
// Directed bench for ps2_scan_collector: drives PS/2 frames bit by bit and checks
// strobes, codes and error pulses against hand-computed values.
module tb_ps2_scan_collector;

    localparam int FL  = 8;
    localparam int TMO = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic [31:0] scan_code;
    logic        scan_done_tick;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int both_cnt = 0;
    int bad_chg = 0;
    int t_last_fall = 0;
    int t0, e0, delta;
    logic [31:0] prev_scan = '0;
    logic [31:0] exp_now;
    logic [31:0] exp_q[$];

    ps2_scan_collector #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2c           (ps2c),
        .ps2d           (ps2d),
        .scan_code      (scan_code),
        .scan_done_tick (scan_done_tick),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (reset) begin
            prev_scan = '0;
        end else begin
            if (scan_done_tick) begin
                tick_cnt++;
                exp_now = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check("tick_code", scan_code, exp_now);
            end
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (frame_err && scan_done_tick) both_cnt++;
            if (scan_code !== prev_scan && !scan_done_tick) bad_chg++;
            prev_scan = scan_code;
        end
    end

    task wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task send_bit(input logic b, input int glitch_len);
        ps2d = b;
        wait_cyc(15);
        if (glitch_len > 0) begin
            ps2c = 1'b0;
            wait_cyc(glitch_len);
            ps2c = 1'b1;
        end
        wait_cyc(25);
        ps2c = 1'b0;
        t_last_fall = cyc;
        wait_cyc(30);
        ps2c = 1'b1;
    endtask

    task send_raw(input logic [7:0] data, input logic par, input logic stop,
                  input int nbits, input int glitch_len, input logic [10:0] gmask);
        logic [10:0] fb;
        fb = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fb[i], gmask[i] ? glitch_len : 0);
        ps2d = 1'b1;
        wait_cyc(50);
    endtask

    task send_frame(input logic [7:0] data);
        send_raw(data, ~^data, 1'b1, 11, 0, 11'h000);
    endtask

    initial begin
        wait_cyc(3);
        @(negedge clk);
        check("rst_scan", scan_code, 32'h0);
        check("rst_tick", {31'b0, scan_done_tick}, 32'h0);
        check("rst_err", {31'b0, frame_err}, 32'h0);
        @(posedge clk);
        reset = 1'b0;
        wait_cyc(20);

        // Single press
        t0 = tick_cnt; e0 = err_cnt;
        exp_q.push_back(32'h0000001C);
        send_frame(8'h1C);
        check("press_ticks", tick_cnt - t0, 1);
        check("press_scan", scan_code, 32'h0000001C);
        check("press_err", err_cnt - e0, 0);

        // Press then release
        t0 = tick_cnt;
        exp_q.push_back(32'h0000001C);
        send_frame(8'h1C);
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("release_ticks", tick_cnt - t0, 1);
        check("release_scan", scan_code, 32'h0000001C);

        // Extended press, extended release, then plain key
        t0 = tick_cnt;
        exp_q.push_back(32'h0000E075);
        send_frame(8'hE0);
        send_frame(8'h75);
        check("ext_ticks", tick_cnt - t0, 1);
        check("ext_scan", scan_code, 32'h0000E075);
        t0 = tick_cnt;
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("ext_rel_ticks", tick_cnt - t0, 0);
        check("ext_rel_scan", scan_code, 32'h0000E075);
        exp_q.push_back(32'h00000045);
        send_frame(8'h45);
        check("ext_clr_scan", scan_code, 32'h00000045);

        // Parity error, recovery, stop-bit error
        t0 = tick_cnt; e0 = err_cnt;
        send_raw(8'h16, 1'b1, 1'b1, 11, 0, 11'h000);
        check("par_err_cnt", err_cnt - e0, 1);
        check("par_err_ticks", tick_cnt - t0, 0);
        exp_q.push_back(32'h00000016);
        send_frame(8'h16);
        check("par_recover_scan", scan_code, 32'h00000016);
        t0 = tick_cnt; e0 = err_cnt;
        send_raw(8'h16, 1'b0, 1'b0, 11, 0, 11'h000);
        check("stop_err_cnt", err_cnt - e0, 1);
        check("stop_err_ticks", tick_cnt - t0, 0);
        check("stop_err_scan", scan_code, 32'h00000016);

        // Timeout after start bit plus 4 data bits
        t0 = tick_cnt; e0 = err_cnt;
        send_raw(8'h45, 1'b0, 1'b1, 5, 0, 11'h000);
        wait_cyc(TMO + 100);
        check("tmo_err_cnt", err_cnt - e0, 1);
        delta = err_cyc - t_last_fall;
        check("tmo_window", {31'b0, (delta >= TMO) && (delta <= TMO + FL + 12)}, 32'h1);
        exp_q.push_back(32'h00000045);
        send_frame(8'h45);
        check("tmo_recover_scan", scan_code, 32'h00000045);
        check("tmo_ticks", tick_cnt - t0, 1);

        // Reset mid-frame
        send_raw(8'h33, 1'b1, 1'b1, 4, 0, 11'h000);
        @(posedge clk);
        reset = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        check("midrst_scan", scan_code, 32'h0);
        check("midrst_tick", {31'b0, scan_done_tick}, 32'h0);
        check("midrst_err", {31'b0, frame_err}, 32'h0);
        @(posedge clk);
        reset = 1'b0;
        wait_cyc(20);
        exp_q.push_back(32'h00000029);
        send_frame(8'h29);
        check("midrst_recover_scan", scan_code, 32'h00000029);

        // Short glitches between every bit are filtered out
        t0 = tick_cnt; e0 = err_cnt;
        exp_q.push_back(32'h0000001E);
        send_raw(8'h1E, ~^8'h1E, 1'b1, 11, FL - 1, 11'h7FF);
        check("glitch_short_scan", scan_code, 32'h0000001E);
        check("glitch_short_ticks", tick_cnt - t0, 1);
        check("glitch_short_err", err_cnt - e0, 0);

        // A full-length glitch before d0 adds a bit and breaks parity
        t0 = tick_cnt; e0 = err_cnt;
        send_raw(8'h1E, ~^8'h1E, 1'b1, 11, FL, 11'h002);
        wait_cyc(TMO + 100);
        check("glitch_long_err", {31'b0, (err_cnt - e0) >= 1}, 32'h1);
        check("glitch_long_ticks", tick_cnt - t0, 0);
        check("glitch_long_scan", scan_code, 32'h0000001E);

        check("tick_err_overlap", both_cnt, 0);
        check("scan_changed_without_tick", bad_chg, 0);
        check("expected_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
